// File: rtl/video_line_packer.sv
// Ping-pong line store: accepts a gappy pixel stream, re-emits each complete line as one
// gap-free burst with frame/line markers, and flags frames whose length disagrees with s_tlast.
module video_line_packer #(
  parameter int DATA_W = 8,
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              m_teof,
  input  logic              m_tready,
  output logic              err_early,
  output logic              err_missing,
  output logic [15:0]       frame_cnt
);
  // Handshake: a beat moves on a rising edge where valid and ready are both high; valid,
  // once raised, holds its data steady until the beat is taken.

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [0:0] {O_IDLE, O_SEND} o_state_e;

  logic [DATA_W-1:0] mem_q [2][WIDTH];
  logic [1:0]        full_q, full_d;
  logic              wb_q, rb_q, rdy_en_q;
  logic [CNT_W-1:0]  wr_x_q, wr_y_q, rd_x_q;
  logic [CNT_W-1:0]  line_y_q [2];
  o_state_e          o_state_q;
  logic              m_tvalid_q, err_early_q, err_missing_q;
  logic [15:0]       frame_cnt_q;

  logic             s_fire, m_fire, frame_end, tlast_early, line_done, rd_line_done;
  logic [CNT_W-1:0] rd_y;

  assign s_tready     = rdy_en_q & ~full_q[wb_q];
  assign s_fire       = s_tvalid & s_tready;
  assign frame_end    = (wr_x_q == X_LAST) && (wr_y_q == Y_LAST);
  assign tlast_early  = s_fire & s_tlast & ~frame_end;
  assign line_done    = s_fire & ~tlast_early & (wr_x_q == X_LAST);
  assign m_fire       = m_tvalid_q & m_tready;
  assign rd_line_done = m_fire & (rd_x_q == X_LAST);

  // The row index travels with each stored line, so a resync after an early s_tlast
  // restarts the output row count exactly at the first line of the new frame.
  assign rd_y = line_y_q[rb_q];

  assign m_tvalid    = m_tvalid_q;
  assign m_tdata     = mem_q[rb_q][rd_x_q[XW-1:0]];
  assign m_tlast     = m_tvalid_q & (rd_x_q == X_LAST);
  assign m_tuser     = m_tvalid_q & (rd_x_q == '0) & (rd_y == '0);
  assign m_teof      = m_tlast & (rd_y == Y_LAST);
  assign err_early   = err_early_q;
  assign err_missing = err_missing_q;
  assign frame_cnt   = frame_cnt_q;

  // A bank is never set and cleared on the same edge: the writer only fills a non-full bank.
  always_comb begin
    full_d = full_q;
    if (rd_line_done) full_d[rb_q] = 1'b0;
    if (line_done)    full_d[wb_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (s_fire) mem_q[wb_q][wr_x_q[XW-1:0]] <= s_tdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en_q      <= 1'b0;
      full_q        <= '0;
      wb_q          <= 1'b0;
      wr_x_q        <= '0;
      wr_y_q        <= '0;
      line_y_q[0]   <= '0;
      line_y_q[1]   <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      rdy_en_q      <= 1'b1;
      full_q        <= full_d;
      err_early_q   <= tlast_early;
      err_missing_q <= s_fire & frame_end & ~s_tlast;
      if (s_fire) begin
        if (tlast_early) begin
          wr_x_q <= '0;
          wr_y_q <= '0;
        end else if (wr_x_q == X_LAST) begin
          wr_x_q         <= '0;
          wr_y_q         <= (wr_y_q == Y_LAST) ? '0 : wr_y_q + ONE;
          wb_q           <= ~wb_q;
          line_y_q[wb_q] <= wr_y_q;
        end else begin
          wr_x_q <= wr_x_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_state_q   <= O_IDLE;
      m_tvalid_q  <= 1'b0;
      rd_x_q      <= '0;
      rb_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (o_state_q)
        O_IDLE: begin
          if (full_q[rb_q]) begin
            o_state_q  <= O_SEND;
            m_tvalid_q <= 1'b1;
          end
        end
        O_SEND: begin
          if (m_fire) begin
            if (m_teof) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (rd_x_q == X_LAST) begin
              rd_x_q <= '0;
              rb_q   <= ~rb_q;
              // Chain straight into the other bank only if it was already full.
              if (!full_q[~rb_q]) begin
                o_state_q  <= O_IDLE;
                m_tvalid_q <= 1'b0;
              end
            end else begin
              rd_x_q <= rd_x_q + ONE;
            end
          end
        end
        default: begin
          o_state_q  <= O_IDLE;
          m_tvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_line_packer.sv
// Randomized bench for video_line_packer: a line-level reference model turns accepted pixels
// into the expected output beat stream, error pulses and frame count.
module tb_video_line_packer;
  localparam int DW = 8, W = 16, H = 10, CW = 10, QW = DW + 3;

  logic          clk = 1'b0, rstn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast, m_teof;
  logic          m_tready = 1'b1;
  logic          err_early, err_missing;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  video_line_packer #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_teof(m_teof), .m_tready(m_tready),
    .err_early(err_early), .err_missing(err_missing), .frame_cnt(frame_cnt)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state; beats are packed {teof, tlast, tuser, data}.
  logic [QW-1:0] exp_q[$];
  logic [DW-1:0] line_buf[$];
  int mx = 0, my = 0, exp_frames = 0, n_acc = 0, n_early_seen = 0, n_missing_seen = 0;
  bit pend_early = 0, pend_missing = 0, prev_stall = 0, mid_line = 0;
  logic [QW-1:0] prev_out, out_now, exp_beat;
  int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    bit frame_last;
    frame_last = (mx == W-1) && (my == H-1);
    n_acc++;
    if (last && !frame_last) begin
      pend_early = 1;
      line_buf.delete();
      mx = 0;
      my = 0;
      return;
    end
    if (frame_last && !last) pend_missing = 1;
    line_buf.push_back(d);
    if (mx == W-1) begin
      for (int i = 0; i < W; i++)
        exp_q.push_back({(i == W-1) && (my == H-1), i == W-1, (i == 0) && (my == 0), line_buf[i]});
      line_buf.delete();
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      line_buf.delete();
      mx = 0; my = 0; exp_frames = 0;
      pend_early = 0; pend_missing = 0; prev_stall = 0; mid_line = 0;
    end else begin
      out_now = {m_teof, m_tlast, m_tuser, m_tdata};
      check("err_early", err_early, pend_early);
      check("err_missing", err_missing, pend_missing);
      check("frame_cnt", frame_cnt, exp_frames);
      if (err_early) n_early_seen++;
      if (err_missing) n_missing_seen++;
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_hold", out_now, prev_out);
      end else if (mid_line) begin
        check("burst_gap", m_tvalid, 1);
      end
      if (m_tvalid && m_tready) begin
        check("beat_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_beat = exp_q.pop_front();
          check("beat", out_now, exp_beat);
          if (exp_beat[QW-1]) exp_frames++;
          mid_line = !exp_beat[QW-2];
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out = out_now;
      pend_early = 0;
      pend_missing = 0;
      if (s_tvalid && s_tready) model_accept(s_tdata, s_tlast);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic drive_beat(input logic [DW-1:0] d, input logic last);
    int waited = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!s_tready) check("accept_timeout", s_tready, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int gmin, input int gmax, input int ex, input int ey,
                            input bit withhold);
    logic last;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x == W-1 && y == H-1) last = !withhold;
        else last = (x == ex) && (y == ey);
        drive_beat({4'(y), 4'(x)}, last);
        if (x == ex && y == ey) return;
        repeat ($urandom_range(gmax, gmin)) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  int base;

  initial begin
    #12;
    check("rst_outs", {s_tready, m_tvalid, m_tuser, m_tlast, m_teof, err_early, err_missing}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk); #3 rstn = 1'b1;
    @(negedge clk); check("ready_before_edge", s_tready, 0);
    @(posedge clk); @(negedge clk); check("ready_after_edge", s_tready, 1);
    @(posedge clk); #1;

    // 1: sparse source, always-ready sink
    rdy_mode = 0;
    send_frame(3, 3, -1, -1, 0);
    drain();
    check("t1_frames", frame_cnt, 1);

    // 2: continuous source into a stalled sink
    rdy_mode = 1;
    @(posedge clk); #1;
    base = n_acc;
    fork
      send_frame(0, 0, -1, -1, 0);
      begin
        repeat (100) @(negedge clk);
        check("t2_accepted", n_acc - base, 32);
        check("t2_ready_low", s_tready, 0);
        rdy_mode = 0;
      end
    join
    drain();
    check("t2_frames", frame_cnt, 2);

    // 3: early tlast at (5,3), then a clean frame
    base = n_early_seen;
    send_frame(0, 2, 5, 3, 0);
    send_frame(0, 2, -1, -1, 0);
    drain();
    check("t3_early_pulses", n_early_seen - base, 1);
    check("t3_frames", frame_cnt, 3);

    // 4: missing tlast, then a clean frame
    base = n_missing_seen;
    send_frame(0, 1, -1, -1, 1);
    send_frame(0, 1, -1, -1, 0);
    drain();
    check("t4_missing_pulses", n_missing_seen - base, 1);
    check("t4_frames", frame_cnt, 5);

    // 5: random sink backpressure
    rdy_mode = 2;
    send_frame(0, 2, -1, -1, 0);
    drain();
    check("t5_frames", frame_cnt, 6);

    // 6: reset mid-line 4
    for (int i = 0; i < 4*W + 8; i++) begin
      drive_beat({4'(i / W), 4'(i % W)}, 1'b0);
      repeat ($urandom_range(1, 0)) begin @(posedge clk); #1; end
    end
    #1 rstn = 1'b0;
    #1;
    check("t6_rst_outs", {s_tready, m_tvalid, m_tuser, m_tlast, m_teof, err_early, err_missing}, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    check("t6_cnt_after_rst", frame_cnt, 0);
    send_frame(0, 1, -1, -1, 0);
    drain();
    check("t6_frames", frame_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
